// File: rtl/wire_cmd_sequencer.sv
// Host WireIn/WireOut command engine: a toggled sequence bit launches one
// arithmetic command; result, ack and busy are published together.
module wire_cmd_sequencer #(
  parameter int MUL_ITER = 16
) (
  input  logic        ti_clk,
  input  logic        reset,
  input  logic [15:0] cmd_word,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic [15:0] status
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_RUN, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_ACC = 4'd3;
  localparam logic [3:0] OP_CLR = 4'd4;
  localparam logic [3:0] ITER_LAST = 4'(MUL_ITER - 1);

  state_t      state_q, state_d;
  logic        seen_q, seen_d, prev_q;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_q, acc_d, res_q, res_d, pub_q, pub_d;
  logic [31:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [15:0] mplr_q, mplr_d;
  logic [3:0]  iter_q, iter_d;
  logic        busy_q, busy_d, err_q, err_d, ovr_q, ovr_d, ack_q, ack_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [16:0] sum17, dif17;
  logic        unused_cmd;

  assign unused_cmd = ^cmd_word[14:4];
  assign sum17 = {1'b0, a_q} + {1'b0, b_q};
  assign dif17 = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    pub_d   = pub_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_word[15] != seen_q) begin
          seen_d  = cmd_word[15];
          op_d    = cmd_word[3:0];
          a_d     = opa;
          b_d     = opb;
          busy_d  = 1'b1;
          prod_d  = '0;
          mcand_d = {16'b0, opa};
          mplr_d  = opb;
          iter_d  = '0;
          state_d = (cmd_word[3:0] == OP_MUL) ? MUL_RUN : EXEC;
        end
      end
      MUL_RUN: begin
        if (mplr_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        iter_d  = iter_q + 4'd1;
        // MUL funnels through EXEC so every opcode shares the same publish path
        if (iter_q == ITER_LAST) state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: res_d = {15'b0, sum17};
          OP_SUB: res_d = {{15{dif17[16]}}, dif17};
          OP_MUL: res_d = prod_q;
          OP_ACC: begin
            acc_d = acc_q + {16'b0, a_q};
            res_d = acc_d;
          end
          OP_CLR: begin
            acc_d = '0;
            res_d = '0;
            ovr_d = 1'b0;
          end
          default: res_d = res_q;
        endcase
        state_d = DONE;
      end
      DONE: begin
        pub_d   = res_q;
        err_d   = (op_q > OP_CLR);
        ack_d   = seen_q;
        busy_d  = 1'b0;
        cnt_d   = cnt_q + 7'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A toggle that lands while busy wins over a same-cycle CLR
    if (state_q != IDLE && cmd_word[15] != prev_q) ovr_d = 1'b1;
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
      prev_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      pub_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      prev_q  <= cmd_word[15];
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      pub_q   <= pub_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result_lo = pub_q[15:0];
  assign result_hi = pub_q[31:16];
  assign status    = {ack_q, cnt_q, 5'b0, ovr_q, err_q, busy_q};

endmodule
